skewed_accumulator_bank: RTL and testbench

Parametrised, diagonally-skewed accumulator memory sitting below the systolic array. Column j of logical address A lives at physical row (A - j) mod DEPTH, so row-skewed array outputs land aligned. Adds an internal read-modify-write write pipeline with forwarding, overwrite/wrap/saturate modes, an independent read port with valid, and a sequenced clear. Operates without an external read-back loop.

---
 rtl/skewed_accumulator_bank.sv | 151 +++++++++++++++
 tb/tb_skewed_accumulator_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skewed_accumulator_bank.sv
// Diagonally skewed accumulator bank: column j of logical address A lives at physical
// row (A - j) mod DEPTH. Writes go through a 2-stage read-modify-write pipeline with forwarding.
module skewed_accumulator_bank #(
    parameter int unsigned COLS   = 32,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    output logic              busy_o,
    input  logic              wr_en_i,
    input  logic [1:0]        wr_mode_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [COLS-1:0]   wr_mask_i,
    input  logic [DATA_W-1:0] wr_data_i [COLS],
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o [COLS],
    output logic              rd_valid_o,
    output logic              sat_flag_o
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    typedef enum logic [1:0] {
        MODE_OVR  = 2'b00,
        MODE_WRAP = 2'b01,
        MODE_SAT  = 2'b10,
        MODE_RSV  = 2'b11
    } mode_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_row_q;
    logic              idle;
    logic              clear_acc;
    logic              rd_acc;
    logic              commit;

    logic              s2_valid_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [COLS-1:0]   s2_mask_q;
    mode_t             s2_mode_q;
    logic [DATA_W-1:0] s2_data_q [COLS];
    logic [DATA_W-1:0] s2_old_q  [COLS];
    logic [DATA_W-1:0] s1_old    [COLS];
    logic [DATA_W-1:0] rd_next   [COLS];
    logic [COLS-1:0]   clamp;

    assign idle      = (state_q == ST_IDLE);
    assign busy_o    = (state_q == ST_CLEAR);
    assign clear_acc = idle && clear_i;
    assign rd_acc    = idle && rd_en_i;
    // A write accepted alongside clear_i never sets s2_valid_q, so it is dropped.
    assign commit    = s2_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clear_i) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_row_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            clr_row_q  <= '0;
            s2_valid_q <= 1'b0;
            rd_valid_o <= 1'b0;
            sat_flag_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (clear_acc)
                clr_row_q <= '0;
            else if (busy_o)
                clr_row_q <= clr_row_q + ADDR_W'(1);
            s2_valid_q <= idle && wr_en_i && !clear_i;
            rd_valid_o <= rd_acc;
            if (clear_acc)
                sat_flag_o <= 1'b0;
            else if (commit && |(clamp & s2_mask_q))
                sat_flag_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        s2_addr_q <= wr_addr_i;
        s2_mask_q <= wr_mask_i;
        s2_mode_q <= mode_t'(wr_mode_i);
        for (int unsigned j = 0; j < COLS; j++) begin
            s2_data_q[j] <= wr_data_i[j];
            s2_old_q[j]  <= s1_old[j];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned j = 0; j < COLS; j++) begin
            if (rst_i)
                rd_data_o[j] <= '0;
            else
                rd_data_o[j] <= rd_acc ? rd_next[j] : '0;
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam logic [ADDR_W-1:0] SKEW = ADDR_W'(j);

        logic [DATA_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] wr_row, s2_row, rd_row;
        logic [DATA_W:0]   sum_ext;
        logic [DATA_W-1:0] new_word;
        logic              ovf;

        assign wr_row = wr_addr_i - SKEW;
        assign s2_row = s2_addr_q - SKEW;
        assign rd_row = rd_addr_i - SKEW;

        // Sign-extended sum: overflow shows as disagreement of the top two bits.
        always_comb begin
            sum_ext  = {s2_old_q[j][DATA_W-1], s2_old_q[j]} + {s2_data_q[j][DATA_W-1], s2_data_q[j]};
            ovf      = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
            new_word = s2_data_q[j];
            case (s2_mode_q)
                MODE_WRAP: new_word = sum_ext[DATA_W-1:0];
                MODE_SAT: begin
                    if (!ovf)
                        new_word = sum_ext[DATA_W-1:0];
                    else if (sum_ext[DATA_W])
                        new_word = {1'b1, {(DATA_W-1){1'b0}}};
                    else
                        new_word = {1'b0, {(DATA_W-1){1'b1}}};
                end
                default:   new_word = s2_data_q[j];
            endcase
        end

        assign clamp[j]   = (s2_mode_q == MODE_SAT) && ovf;
        assign s1_old[j]  = (commit && s2_mask_q[j] && (s2_addr_q == wr_addr_i)) ? new_word : mem[wr_row];
        assign rd_next[j] = (commit && s2_mask_q[j] && (s2_addr_q == rd_addr_i)) ? new_word : mem[rd_row];

        always_ff @(posedge clk_i) begin
            if (busy_o)
                mem[clr_row_q] <= '0;
            else if (commit && s2_mask_q[j])
                mem[s2_row] <= new_word;
        end
    end

endmodule

// File: tb/tb_skewed_accumulator_bank.sv
// Scoreboard bench for skewed_accumulator_bank: a logical-address reference model predicts
// every cycle's read response, busy_o and sat_flag_o.
module tb_skewed_accumulator_bank;

    localparam int unsigned COLS   = 32;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    typedef logic [COLS-1:0][DATA_W-1:0] row_t;
    typedef struct packed {
        logic v;
        logic chk;
        row_t d;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst, clear, wr_en, rd_en;
    logic [1:0]        wr_mode;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [COLS-1:0]   wr_mask;
    logic [DATA_W-1:0] wr_data [COLS];
    logic [DATA_W-1:0] rd_data [COLS];
    logic              busy, rd_valid, sat_flag;

    int   n_asserts = 0;
    int   n_fail    = 0;
    row_t ref_mem [DEPTH];
    bit   mem_known;
    int   busy_cnt;
    bit   exp_sat, sat_pend;
    exp_t sbq [$];
    logic [COLS-1:0] lo_mask;

    always #5 clk = ~clk;

    skewed_accumulator_bank #(
        .COLS  (COLS),
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (clear),
        .busy_o    (busy),
        .wr_en_i   (wr_en),
        .wr_mode_i (wr_mode),
        .wr_addr_i (wr_addr),
        .wr_mask_i (wr_mask),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .rd_valid_o(rd_valid),
        .sat_flag_o(sat_flag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        rst     = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_mode = 2'b00;
        wr_addr = '0;
        rd_addr = '0;
        wr_mask = '0;
        for (int j = 0; j < COLS; j++) wr_data[j] = '0;
    endtask

    task automatic wr(input logic [1:0] mode, input int addr, input logic [COLS-1:0] mask,
                      input logic [DATA_W-1:0] val);
        wr_en   = 1'b1;
        wr_mode = mode;
        wr_addr = addr[ADDR_W-1:0];
        wr_mask = mask;
        for (int j = 0; j < COLS; j++) wr_data[j] = val;
    endtask

    task automatic rd(input int addr);
        rd_en   = 1'b1;
        rd_addr = addr[ADDR_W-1:0];
    endtask

    task automatic apply_write();
        logic [DATA_W-1:0] old;
        longint s;
        longint maxv, minv;
        maxv = (longint'(1) <<< (DATA_W - 1)) - 1;
        minv = -(longint'(1) <<< (DATA_W - 1));
        for (int j = 0; j < COLS; j++) begin
            if (wr_mask[j]) begin
                old = ref_mem[wr_addr][j];
                case (wr_mode)
                    2'b01: ref_mem[wr_addr][j] = old + wr_data[j];
                    2'b10: begin
                        s = longint'($signed(old)) + longint'($signed(wr_data[j]));
                        if (s > maxv) begin
                            s = maxv;
                            sat_pend = 1'b1;
                        end else if (s < minv) begin
                            s = minv;
                            sat_pend = 1'b1;
                        end
                        ref_mem[wr_addr][j] = s[DATA_W-1:0];
                    end
                    default: ref_mem[wr_addr][j] = wr_data[j];
                endcase
            end
        end
    endtask

    // One clock cycle: predict, push, clock, pop and compare, then release inputs.
    task automatic tick();
        exp_t e;
        bit   idle;
        idle = (busy_cnt == 0);
        e    = '0;
        e.chk = 1'b1;
        if (rst) begin
            busy_cnt  = 0;
            exp_sat   = 1'b0;
            sat_pend  = 1'b0;
            mem_known = 1'b0;
        end else begin
            if (busy_cnt > 0) busy_cnt--;
            if (idle && clear)
                exp_sat = 1'b0;
            else if (sat_pend)
                exp_sat = 1'b1;
            sat_pend = 1'b0;
            if (idle) begin
                e.v   = rd_en;
                e.chk = !rd_en || mem_known;
                e.d   = rd_en ? ref_mem[rd_addr] : '0;
                if (clear) begin
                    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
                    mem_known = 1'b1;
                    busy_cnt  = DEPTH;
                end else if (wr_en) begin
                    apply_write();
                end
            end else begin
                e.v   = 1'b0;
                e.chk = 1'b0;
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("rd_valid", rd_valid, e.v);
        if (e.chk)
            for (int j = 0; j < COLS; j++)
                check($sformatf("rd_data[%0d]", j), rd_data[j], e.d[j]);
        check("busy", busy, busy_cnt > 0);
        check("sat_flag", sat_flag, exp_sat);
        idle_in();
    endtask

    initial begin
        int pick;
        idle_in();
        mem_known = 1'b0;
        busy_cnt  = 0;
        exp_sat   = 1'b0;
        sat_pend  = 1'b0;
        lo_mask   = '0;
        for (int j = 0; j < COLS / 2; j++) lo_mask[j] = 1'b1;

        rst = 1'b1; tick();
        rst = 1'b1; tick();
        tick();

        clear = 1'b1; tick();
        repeat (DEPTH) tick();
        for (int a = 0; a < DEPTH; a++) begin rd(a); tick(); end
        tick();

        // skew and row wrap
        wr(2'b00, 3, '1, 0);
        for (int j = 0; j < COLS; j++) wr_data[j] = DATA_W'(j + 1);
        tick();
        wr(2'b00, 126, '1, 32'hA5); tick();
        rd(3); tick(); rd(126); tick(); rd(125); tick();

        // back-to-back accumulate to one address
        repeat (4) begin wr(2'b01, 10, '1, 7); tick(); end
        rd(10); tick();

        // wrap overflow, masked-out saturation, reserved mode
        wr(2'b00, 32, '1, 32'h7FFF_FFF0); tick();
        wr(2'b01, 32, '1, 32'h20); tick();
        rd(32); tick(); tick();
        wr(2'b00, 33, '1, 32'h7FFF_FFF0); tick();
        wr(2'b10, 33, '0, 32'h20); tick();
        rd(33); tick(); tick();
        wr(2'b00, 34, '1, 5); tick();
        wr(2'b11, 34, '1, 32'h1234); tick();
        rd(34); tick();

        // saturation both directions
        wr(2'b00, 30, '1, 32'h7FFF_FFF0); tick();
        wr(2'b10, 30, '1, 32'h20); tick();
        rd(30); tick(); tick();
        wr(2'b00, 31, '1, 32'h8000_0005); tick();
        wr(2'b10, 31, '1, -16); tick();
        rd(31); tick();

        // partial mask with reads in the S1 and S2 cycles
        wr(2'b00, 20, '1, 5); tick();
        wr(2'b00, 20, lo_mask, 9); rd(20); tick();
        rd(20); tick();
        rd(20); tick();

        repeat (80) begin
            if ($urandom_range(0, 3) != 0) begin
                pick = $urandom_range(0, 7);
                wr(2'($urandom_range(0, 3)), (pick < 4) ? pick : 120 + pick, COLS'($urandom), 0);
                for (int j = 0; j < COLS; j++)
                    wr_data[j] = ($urandom_range(0, 1) != 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1) != 0) begin
                pick = $urandom_range(0, 7);
                rd((pick < 4) ? pick : 120 + pick);
            end
            tick();
        end

        // clear together with a write; traffic during the sweep is ignored
        wr(2'b00, 40, '1, 32'h11); tick();
        wr(2'b00, 40, '1, 32'h55); clear = 1'b1; tick();
        repeat (10) tick();
        wr(2'b00, 41, '1, 3); rd(3); clear = 1'b1; tick();
        repeat (DEPTH) tick();
        rd(40); tick(); rd(41); tick(); rd(3); tick(); rd(30); tick();

        // reset in the middle of a sweep
        clear = 1'b1; tick();
        repeat (50) tick();
        rst = 1'b1; tick();
        rd(0); tick();
        tick();
        clear = 1'b1; tick();
        repeat (DEPTH) tick();
        for (int a = 0; a < 4; a++) begin rd(a); tick(); end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
